// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the fetch/data memory arbiter
package mem_arb_pkg;

  // Default memory word-address width.
  localparam int ADDR_W_DEF = 8;

  // Which port owns the read response that returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter_arb2.sv
// rtl/mem_arbiter_arb2.sv - two-way round-robin / fixed-priority grant logic
module arb2 (
  input  logic [1:0] req,       // bit 0 = fetch port, bit 1 = data port
  input  logic       last,      // 1 = data port was granted most recently
  input  logic       prio_mode, // 1 = round robin, 0 = data port always wins
  output logic [1:0] gnt
);

  // One-hot grant; on contention round robin favours the port not used last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio_mode && last) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data port arbiter in front of a single-port sync memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_mask,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out,
  output logic [15:0]       conflict_cnt
);

  owner_e      owner_q;
  owner_e      owner_d;
  logic        last_q;   // 0 = fetch port granted last, 1 = data port
  logic        locked_q; // data port holds the memory for read-modify-write
  logic [15:0] cnt_q;
  logic [1:0]  req;
  logic [1:0]  gnt_raw;
  logic        deny;

  // Fetch is masked while the data port holds the lock.
  assign req = {d_req, i_req & ~locked_q};

  arb2 u_arb2 (
    .req       (req),
    .last      (last_q),
    .prio_mode (RR_EN),
    .gnt       (gnt_raw)
  );

  // Grants are suppressed during reset so nothing reaches the memory.
  assign i_gnt       = gnt_raw[0] & ~rst;
  assign d_gnt       = gnt_raw[1] & ~rst;
  assign mem_request = i_gnt | d_gnt;

  // Any held request that did not win this cycle counts as a conflict.
  assign deny = (i_req & ~i_gnt) | (d_req & ~d_gnt);

  // Steer the granted port onto the memory bus; idle bus is all zeros.
  always_comb begin
    mem_we_re   = 1'b0;
    mem_address = '0;
    mem_data_in = 32'd0;
    mem_mask    = 4'd0;
    if (i_gnt) begin
      mem_address = i_addr;
    end else if (d_gnt) begin
      mem_we_re   = d_we;
      mem_address = d_addr;
      mem_data_in = d_wdata;
      mem_mask    = d_we ? d_mask : 4'd0;
    end
  end

  // Next response owner: only reads produce a response.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_I;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  // Response owner state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Remember the last granted port; reset to fetch so data wins first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else if (mem_request) begin
      last_q <= d_gnt;
    end
  end

  // Lock is taken by a locked data grant and released on the first cycle without d_lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= d_lock ? (locked_q | d_gnt) : 1'b0;
    end
  end

  // Saturating conflict counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (deny && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = cnt_q;
  assign i_rvalid     = (owner_q == OWN_I) & ~rst;
  assign d_rvalid     = (owner_q == OWN_D) & ~rst;
  assign i_rdata      = i_rvalid ? mem_data_out : 32'd0;
  assign d_rdata      = d_rvalid ? mem_data_out : 32'd0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W, default 8, memory word-address width; and RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed data-port priority.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req  input  1  instruction-fetch read request.
REQ-005 i_addr  input  ADDR_W  fetch word address.
REQ-006 i_gnt  output  1  fetch request accepted this cycle.
REQ-007 i_rvalid  output  1  i_rdata valid.
REQ-008 i_rdata  output  32  fetch read data.
REQ-009 d_req  input  1  load/store request.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  ADDR_W  data word address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_mask  input  4  store byte enables.
REQ-014 d_lock  input  1  hold memory ownership for the data port, for read-modify-write.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  d_rdata valid, loads only.
REQ-017 d_rdata  output  32  load data.
REQ-018 mem_request, mem_we_re, mem_address[ADDR_W], mem_data_in[32], mem_mask[4]  outputs  drive the single-port synchronous memory.
REQ-019 mem_data_out  input  32  memory read data, registered inside memory on the cycle of the read request.
REQ-020 conflict_cnt  output  16  saturating count of cycles in which a request was denied.

Function
REQ-021 Arbitration SHALL be combinational within a cycle; at most one of i_gnt/d_gnt SHALL be high, and mem_request = i_gnt | d_gnt.
REQ-022 A sole requester SHALL be granted in the same cycle it asserts its request.
REQ-023 On simultaneous requests with RR_EN=1, the grant SHALL go to the port not granted most recently (last_owner register); with RR_EN=0, d_req SHALL always win.
REQ-024 Lock: a data grant with d_lock=1 SHALL set the locked flag; while it is set, i_gnt SHALL be 0; the flag SHALL clear on the first cycle with d_lock=0.
REQ-025 On an i grant, the block SHALL drive mem_we_re=0, mem_address=i_addr, mem_data_in=0, and mem_mask=0.
REQ-026 On a d grant, the block SHALL drive mem_we_re=d_we, mem_address=d_addr, mem_data_in=d_wdata, and mem_mask = d_we ? d_mask : 0.
REQ-027 With no grant, all mem_* outputs SHALL be 0.
REQ-028 Read latency SHALL be 1 cycle: a read granted in cycle N SHALL raise the owner's rvalid in cycle N+1 for exactly one cycle, with rdata=mem_data_out.
REQ-029 A store SHALL produce no rvalid.
REQ-030 Back-to-back reads from either or alternating ports SHALL sustain one grant per cycle; the response owner SHALL be tracked in a registered owner state of NONE, I, or D.
REQ-031 Owner state transitions: any state -> I on an i read grant; any state -> D on a d read grant; any state -> NONE otherwise, including on a store.
REQ-032 rdata on the port not flagged by rvalid SHALL be 0.
REQ-033 conflict_cnt SHALL increment by 1 per cycle in which any requester is denied, including lock-denied cycles, and SHALL saturate at 16'hFFFF.
REQ-034 Request inputs SHALL be allowed to change every cycle; a denied request that is still held SHALL be re-arbitrated the next cycle, with no queueing.

Reset
REQ-035 While rst=1, the block SHALL force i_gnt, d_gnt, all mem_* outputs, i_rvalid, d_rvalid, i_rdata, d_rdata to 0 regardless of inputs.
REQ-036 Reset SHALL set the owner state to NONE, last_owner to I (so the first contention under RR_EN=1 grants D), the locked flag to 0, and conflict_cnt to 0.
REQ-037 A read granted in the cycle rst asserts SHALL never produce rvalid, including after rst deasserts.

Structure
REQ-038 The package mem_arb_pkg SHALL hold the owner_e enum (OWN_NONE, OWN_I, OWN_D) and the default ADDR_W constant.
REQ-039 The two-way round-robin/fixed-priority grant logic SHALL be one sub-module, arb2, with inputs req[1:0], last, and prio_mode and output gnt[1:0].

Verification
REQ-040 Bench: i_req only, i_addr=8'h04, memory word 4 = 32'hDEADBEEF -> i_gnt in cycle 0; i_rvalid=1 and i_rdata=32'hDEADBEEF in cycle 1.
REQ-041 Bench: i_req and d_req (load 8'h10) both high for 4 cycles, RR_EN=1 -> grants D, I, D, I; conflict_cnt=4.
REQ-042 Bench: d store 8'h20, d_wdata=32'h11223344, d_mask=4'b0011 onto word 32'hAAAAAAAA, then load 8'h20 -> d_rvalid with 32'hAAAA3344; no rvalid after the store.
REQ-043 Bench: d_lock=1 with d_req over 3 cycles while i_req is held -> i_gnt=0 throughout; i granted the cycle after d_lock drops.
REQ-044 Bench: assert rst in the cycle following a granted read -> rvalid stays 0; conflict_cnt=0 and all outputs 0 while rst=1.
REQ-045 Bench: force 70000 contention cycles -> conflict_cnt holds at 16'hFFFF.
